maxnet_feeder: RTL and testbench

MAXNET_FEEDER -- requirements
Module: maxnet_feeder

---
 rtl/maxnet_feeder_pkg.sv | 18 +
 rtl/maxnet_argmax_tracker.sv | 32 +++
 rtl/maxnet_feeder.sv | 156 +++++++++++++++
 tb/tb_maxnet_feeder.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maxnet_feeder_pkg.sv
// Shared types and constants for the Maxnet feeder: FSM states, beat and
// neuron counts, and the argmax index width.
package maxnet_feeder_pkg;

    localparam int NUM_BEATS   = 5;
    localparam int NUM_NEURONS = 4;
    localparam int IDX_W       = $clog2(NUM_NEURONS);
    localparam int BEAT_W      = 3;

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_INIT,
        ST_START,
        ST_WAIT,
        ST_RESP
    } state_t;

endpackage

// File: rtl/maxnet_argmax_tracker.sv
// Running unsigned maximum over the loaded activations. A strict greater-than
// compare keeps the lowest index on ties.
module maxnet_argmax_tracker
    import maxnet_feeder_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              update,
    input  logic [DATA_W-1:0] value,
    input  logic [IDX_W-1:0]  index,
    output logic [IDX_W-1:0]  max_index
);

    logic [DATA_W-1:0] max_value;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            max_value <= '0;
            max_index <= '0;
        end else if (clear) begin
            max_value <= '0;
            max_index <= '0;
        end else if (update && (value > max_value)) begin
            max_value <= value;
            max_index <= index;
        end
    end

endmodule

// File: rtl/maxnet_feeder.sv
// Loads epsilon and four activations into a Maxnet datapath, starts it,
// waits for convergence (or timeout) and hands back the survivor and argmax.
module maxnet_feeder
    import maxnet_feeder_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic [DATA_W-1:0] net_eps,
    output logic [DATA_W-1:0] net_a1,
    output logic [DATA_W-1:0] net_a2,
    output logic [DATA_W-1:0] net_a3,
    output logic [DATA_W-1:0] net_a4,
    output logic              net_load,
    output logic              net_start,
    input  logic              net_finish,
    input  logic [DATA_W-1:0] net_out,
    output logic              r_valid,
    input  logic              r_ready,
    output logic [DATA_W-1:0] r_value,
    output logic [1:0]        r_index,
    output logic              r_timeout
);

    localparam int CNT_W = $clog2(TIMEOUT) + 1;
    // The counter reaches TIMEOUT-1 on the increment made while it holds TIMEOUT-2.
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 2);

    state_t state, next_state;

    logic [BEAT_W-1:0]                  beat_cnt;
    logic [CNT_W-1:0]                   wait_cnt;
    logic [NUM_NEURONS-1:0][DATA_W-1:0] load_buf;
    logic                               accept;
    logic                               last_beat;
    logic                               expire;
    logic                               handshake;
    logic [IDX_W-1:0]                   act_index;

    assign accept    = s_valid && s_ready;
    assign last_beat = (beat_cnt == BEAT_W'(NUM_BEATS - 1));
    assign expire    = (wait_cnt == WAIT_LAST);
    assign handshake = r_valid && r_ready;
    assign act_index = IDX_W'(beat_cnt - BEAT_W'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_LOAD;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        s_ready    = 1'b0;
        net_load   = 1'b0;
        net_start  = 1'b0;
        r_valid    = 1'b0;
        case (state)
            ST_LOAD: begin
                s_ready = 1'b1;
                if (accept && last_beat) begin
                    next_state = ST_INIT;
                end
            end
            ST_INIT: begin
                net_load   = 1'b1;
                next_state = ST_START;
            end
            ST_START: begin
                net_start  = 1'b1;
                next_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (net_finish || expire) begin
                    next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                r_valid = 1'b1;
                if (r_ready) begin
                    next_state = ST_LOAD;
                end
            end
            default: next_state = ST_LOAD;
        endcase
    end

    // Beats are staged in load_buf so the datapath inputs stay put until a full new load lands.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat_cnt  <= '0;
            wait_cnt  <= '0;
            load_buf  <= '0;
            net_eps   <= '0;
            net_a1    <= '0;
            net_a2    <= '0;
            net_a3    <= '0;
            net_a4    <= '0;
            r_value   <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (accept) begin
                if (last_beat) begin
                    beat_cnt <= '0;
                    net_eps  <= load_buf[0];
                    net_a1   <= load_buf[1];
                    net_a2   <= load_buf[2];
                    net_a3   <= load_buf[3];
                    net_a4   <= s_data;
                end else begin
                    beat_cnt                     <= beat_cnt + BEAT_W'(1);
                    load_buf[beat_cnt[IDX_W-1:0]] <= s_data;
                end
            end

            if (state == ST_START) begin
                wait_cnt <= '0;
            end else if (state == ST_WAIT) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end

            if (state == ST_WAIT) begin
                if (net_finish) begin
                    r_value   <= net_out;
                    r_timeout <= 1'b0;
                end else if (expire) begin
                    r_value   <= '0;
                    r_timeout <= 1'b1;
                end
            end else if (handshake) begin
                r_value   <= '0;
                r_timeout <= 1'b0;
            end
        end
    end

    maxnet_argmax_tracker #(
        .DATA_W (DATA_W)
    ) u_argmax (
        .clk       (clk),
        .rst       (rst),
        .clear     (handshake),
        .update    (accept && (beat_cnt != '0)),
        .value     (s_data),
        .index     (act_index),
        .max_index (r_index)
    );

endmodule

// File: tb/tb_maxnet_feeder.sv
// Scoreboard bench for maxnet_feeder: directed loads with hand-computed
// results, a behavioural datapath model and decoupled load/result monitors.
module tb_maxnet_feeder;

    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;

    typedef logic [4:0][DATA_W-1:0] load_t;
    typedef struct packed {
        logic [DATA_W-1:0] value;
        logic [1:0]        index;
        logic              timeout;
        int                lat;
    } res_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic [DATA_W-1:0] net_eps, net_a1, net_a2, net_a3, net_a4;
    logic              net_load, net_start;
    logic              net_finish;
    logic [DATA_W-1:0] net_out;
    logic              r_valid, r_ready;
    logic [DATA_W-1:0] r_value;
    logic [1:0]        r_index;
    logic              r_timeout;

    int    vectors     = 0;
    int    miscompares = 0;
    int    cyc         = 0;
    int    last_beat_cyc = 0;
    int    start_cyc   = 0;
    int    load_cycles = 0;
    int    start_cycles = 0;
    int    exp_loads   = 0;
    int    fin_delay   = -1;
    logic [DATA_W-1:0] fin_val = '0;
    load_t load_q[$];
    res_t  res_q[$];

    maxnet_feeder #(
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .net_eps    (net_eps),
        .net_a1     (net_a1),
        .net_a2     (net_a2),
        .net_a3     (net_a3),
        .net_a4     (net_a4),
        .net_load   (net_load),
        .net_start  (net_start),
        .net_finish (net_finish),
        .net_out    (net_out),
        .r_valid    (r_valid),
        .r_ready    (r_ready),
        .r_value    (r_value),
        .r_index    (r_index),
        .r_timeout  (r_timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [63:0] actual,
                                input logic [63:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_output({tag, ".s_ready"},   64'(s_ready),   64'd1);
        check_output({tag, ".r_valid"},   64'(r_valid),   64'd0);
        check_output({tag, ".net_load"},  64'(net_load),  64'd0);
        check_output({tag, ".net_start"}, 64'(net_start), 64'd0);
        check_output({tag, ".net_words"}, 64'(net_eps | net_a1 | net_a2 | net_a3 | net_a4), 64'd0);
        check_output({tag, ".r_value"},   64'(r_value),   64'd0);
        check_output({tag, ".r_index"},   64'(r_index),   64'd0);
        check_output({tag, ".r_timeout"}, 64'(r_timeout), 64'd0);
    endtask

    // Behavioural datapath: raises net_finish fin_delay cycles after net_start.
    initial begin
        int  cnt;
        bit  armed;
        net_finish = 1'b0;
        net_out    = '0;
        armed      = 1'b0;
        cnt        = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                armed      = 1'b0;
                net_finish = 1'b0;
            end else if (net_start) begin
                armed = 1'b1;
                cnt   = 0;
            end else if (armed) begin
                if (r_valid) begin
                    armed      = 1'b0;
                    net_finish = 1'b0;
                end else begin
                    cnt++;
                    if (cnt == fin_delay) begin
                        net_finish = 1'b1;
                        net_out    = fin_val;
                    end
                end
            end
        end
    end

    // Load-side monitor: datapath words, pulse widths and load/start latency.
    always @(negedge clk) begin
        if (rst && net_load) begin
            load_cycles++;
            check_output("load_latency", 64'(cyc - last_beat_cyc), 64'd1);
            if (load_q.size() == 0) begin
                check_output("unexpected_load", 64'd1, 64'd0);
            end else begin
                load_t w;
                w = load_q.pop_front();
                check_output("net_eps", 64'(net_eps), 64'(w[0]));
                check_output("net_a1",  64'(net_a1),  64'(w[1]));
                check_output("net_a2",  64'(net_a2),  64'(w[2]));
                check_output("net_a3",  64'(net_a3),  64'(w[3]));
                check_output("net_a4",  64'(net_a4),  64'(w[4]));
            end
        end
        if (rst && net_start) begin
            start_cycles++;
            start_cyc = cyc;
            check_output("start_latency", 64'(cyc - last_beat_cyc), 64'd2);
        end
    end

    // Result monitor: every RESP cycle is checked against the head of the queue.
    logic prev_r_valid = 1'b0;
    always @(negedge clk) begin
        if (rst && r_valid) begin
            if (res_q.size() == 0) begin
                check_output("unexpected_result", 64'd1, 64'd0);
            end else begin
                res_t e;
                e = res_q[0];
                if (!prev_r_valid && e.lat >= 0)
                    check_output("result_latency", 64'(cyc - start_cyc), 64'(e.lat));
                check_output("r_value",   64'(r_value),   64'(e.value));
                check_output("r_index",   64'(r_index),   64'(e.index));
                check_output("r_timeout", 64'(r_timeout), 64'(e.timeout));
                if (r_ready) void'(res_q.pop_front());
            end
        end
        prev_r_valid = rst && r_valid;
    end

    task automatic load_words(input load_t w, input bit gaps);
        for (int i = 0; i < 5; i++) begin
            int n;
            s_valid = 1'b0;
            if (gaps) begin
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk);
                    #1;
                end
            end
            n = 0;
            while (!s_ready && n < 100) begin
                @(posedge clk);
                #1;
                n++;
            end
            s_valid = 1'b1;
            s_data  = w[i];
            last_beat_cyc = cyc;
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        s_data  = '0;
        exp_loads++;
    endtask

    task automatic apply_stimulus(input load_t w, input bit gaps, input int delay,
                                  input logic [DATA_W-1:0] fval,
                                  input logic [DATA_W-1:0] exp_value,
                                  input logic [1:0] exp_index, input logic exp_timeout,
                                  input int exp_lat, input int hold);
        res_t e;
        int   n;
        logic got_valid;
        fin_delay = delay;
        fin_val   = fval;
        e.value   = exp_value;
        e.index   = exp_index;
        e.timeout = exp_timeout;
        e.lat     = exp_lat;
        load_q.push_back(w);
        res_q.push_back(e);
        load_words(w, gaps);
        n = 0;
        got_valid = r_valid;
        while (!got_valid && n < 200) begin
            @(posedge clk);
            #1;
            got_valid = r_valid;
            n++;
        end
        check_output("result_wait", 64'(got_valid), 64'd1);
        repeat (hold) begin
            @(posedge clk);
            #1;
        end
        r_ready = 1'b1;
        @(posedge clk);
        #1;
        r_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        load_t w;
        int    n;
        rst     = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        r_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_idle_outputs("reset");
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Basic: argmax at a2, finish after 7 cycles.
        w = {32'd30, 32'd20, 32'd40, 32'd10, 32'h2000};
        apply_stimulus(w, 1'b0, 7, 32'd25, 32'd25, 2'd1, 1'b0, 8, 0);

        // Tie between a1 and a2: lowest index wins.
        w = {32'd10, 32'd10, 32'd50, 32'd50, 32'h100};
        apply_stimulus(w, 1'b0, 3, 32'd50, 32'd50, 2'd0, 1'b0, 4, 0);

        // No finish: timeout response 16 cycles after net_start.
        w = {32'd8, 32'd7, 32'd6, 32'd5, 32'h10};
        apply_stimulus(w, 1'b0, -1, 32'd99, 32'd0, 2'd3, 1'b1, 16, 0);

        // Gapped s_valid and a downstream that stalls for 5 cycles.
        w = {32'd199, 32'd200, 32'd15, 32'd90, 32'h3000};
        apply_stimulus(w, 1'b1, 5, 32'd200, 32'd200, 2'd2, 1'b0, 6, 5);

        // Finish on the expiry cycle: finish takes priority.
        w = {32'd1, 32'd9, 32'd9, 32'd3, 32'd1};
        apply_stimulus(w, 1'b0, 15, 32'd77, 32'd77, 2'd1, 1'b0, 16, 0);

        // Reset while waiting on the datapath.
        fin_delay = -1;
        w = {32'd4, 32'd3, 32'd2, 32'd1, 32'h40};
        load_q.push_back(w);
        load_words(w, 1'b0);
        n = 0;
        while (start_cycles < exp_loads && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_output("reset_test_start", 64'(start_cycles), 64'(exp_loads));
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check_idle_outputs("async_reset");
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check_output("no_start_after_reset", 64'(start_cycles), 64'(exp_loads));
        check_output("reset_idle_ready", 64'(s_ready), 64'd1);

        // Fresh load after reset: argmax at a4.
        w = {32'd7, 32'd0, 32'd0, 32'd0, 32'd0};
        apply_stimulus(w, 1'b0, 2, 32'd7, 32'd7, 2'd3, 1'b0, 3, 0);

        // All-ones boundary with a tie between a1 and a4.
        w = {32'hFFFF_FFFF, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        apply_stimulus(w, 1'b0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd0, 1'b0, 2, 0);

        check_output("load_pulses",  64'(load_cycles),  64'(exp_loads));
        check_output("start_pulses", 64'(start_cycles), 64'(exp_loads));
        check_output("pending_results", 64'(res_q.size()), 64'd0);
        check_output("pending_loads",   64'(load_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
